// File: rtl/kf_axi_pkg.sv
// Shared types and widths for the Kalman-core AXI4 write path.
// Used by the write arbiter and its round-robin picker.
package kf_axi_pkg;

    localparam int AXI_DATA_W  = 512;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/kf_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last+1 (mod N)
// and returns the first requester with req set.
module kf_rr_arbiter #(
    parameter int N = 2,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld
);

    always_comb begin : pick
        int idx;
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        idx     = 0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/kf_axi_wr_arbiter.sv
// Shares one AXI4 write master among NUM_REQ requesters, round-robin per
// transaction; a grant is held from AW acceptance through the B handshake.
module kf_axi_wr_arbiter
    import kf_axi_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,
    parameter int CNT_W   = 16,
    localparam int STRB_W = DATA_W / 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [NUM_REQ-1:0][ADDR_W-1:0]         s_awaddr,
    input  logic [NUM_REQ-1:0][AXI_LEN_W-1:0]      s_awlen,
    input  logic [NUM_REQ-1:0][AXI_SIZE_W-1:0]     s_awsize,
    input  logic [NUM_REQ-1:0][AXI_BURST_W-1:0]    s_awburst,
    input  logic [NUM_REQ-1:0]                     s_awvalid,
    output logic [NUM_REQ-1:0]                     s_awready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]         s_wdata,
    input  logic [NUM_REQ-1:0][STRB_W-1:0]         s_wstrb,
    input  logic [NUM_REQ-1:0]                     s_wlast,
    input  logic [NUM_REQ-1:0]                     s_wvalid,
    output logic [NUM_REQ-1:0]                     s_wready,
    output logic [AXI_RESP_W-1:0]                  s_bresp,
    output logic [NUM_REQ-1:0]                     s_bvalid,
    input  logic [NUM_REQ-1:0]                     s_bready,

    output logic [ADDR_W-1:0]                      m_awaddr,
    output logic [AXI_LEN_W-1:0]                   m_awlen,
    output logic [AXI_SIZE_W-1:0]                  m_awsize,
    output logic [AXI_BURST_W-1:0]                 m_awburst,
    output logic                                   m_awvalid,
    input  logic                                   m_awready,
    output logic [DATA_W-1:0]                      m_wdata,
    output logic [STRB_W-1:0]                      m_wstrb,
    output logic                                   m_wlast,
    output logic                                   m_wvalid,
    input  logic                                   m_wready,
    input  logic [AXI_RESP_W-1:0]                  m_bresp,
    input  logic                                   m_bvalid,
    output logic                                   m_bready,

    output logic [ID_W-1:0]                        grant_id,
    output logic                                   busy,
    output logic                                   wlast_err,
    output logic [CNT_W-1:0]                       txn_cnt
);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [ID_W-1:0]        last_grant;
    logic [ID_W-1:0]        pick_id;
    logic                   pick_vld;
    logic [AXI_LEN_W-1:0]   beats;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;

    kf_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (s_awvalid),
        .last    (last_grant),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    // Master-side valids/readies are already gated by state in the output process.
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;
    assign busy  = (state != IDLE);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld)          state_nxt = ADDR;
            ADDR:    if (aw_hs)             state_nxt = DATA;
            DATA:    if (w_hs && m_wlast)   state_nxt = RESP;
            RESP:    if (b_hs)              state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Only the granted requester's channel is ever connected; everything
    // else reads as zero, which also gives all-zero outputs out of reset.
    always_comb begin
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        case (state)
            ADDR: begin
                m_awaddr            = s_awaddr[grant_id];
                m_awlen             = s_awlen[grant_id];
                m_awsize            = s_awsize[grant_id];
                m_awburst           = s_awburst[grant_id];
                m_awvalid           = s_awvalid[grant_id];
                s_awready[grant_id] = m_awready;
            end
            DATA: begin
                m_wdata             = s_wdata[grant_id];
                m_wstrb             = s_wstrb[grant_id];
                m_wlast             = s_wlast[grant_id];
                m_wvalid            = s_wvalid[grant_id];
                s_wready[grant_id]  = m_wready;
            end
            RESP: begin
                s_bvalid[grant_id]  = m_bvalid;
                s_bresp             = m_bresp;
                m_bready            = s_bready[grant_id];
            end
            default: ;
        endcase
    end

    // beats counts down the remaining beats after the current one; wlast must
    // coincide with beats==0, anything else is flagged and left sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            beats      <= '0;
            wlast_err  <= 1'b0;
            txn_cnt    <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                grant_id <= pick_id;
            end
            if (aw_hs) begin
                beats <= m_awlen;
            end
            if (w_hs) begin
                if (m_wlast) begin
                    if (beats != '0) wlast_err <= 1'b1;
                end else if (beats == '0) begin
                    wlast_err <= 1'b1;
                end else begin
                    beats <= beats - 1'b1;
                end
            end
            if (b_hs) begin
                txn_cnt    <= txn_cnt + 1'b1;
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_kf_axi_wr_arbiter.sv
// Directed bench for kf_axi_wr_arbiter: table of transaction scenarios driven
// through a cycle-level requester/slave model, plus reset corner sequences.
module tb_kf_axi_wr_arbiter;
    import kf_axi_pkg::*;

    localparam int N  = 2;
    localparam int AW = AXI_ADDR_W;
    localparam int DW = AXI_DATA_W;
    localparam int SW = DW / 8;
    localparam int CW = 16;
    localparam int IW = 1;

    typedef enum int {PH_IDLE, PH_PRE, PH_A, PH_W, PH_B} ph_t;

    typedef struct {
        string name;
        bit    do_rst;
        bit    bp;
        bit    en0;  int len0; int wl0;
        bit    en1;  int len1; int wl1; bit early1;
        int    first;
        int    beats;
        bit    err;
        int    txn;
        int    gid;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0][AW-1:0] s_awaddr;
    logic [N-1:0][7:0]    s_awlen;
    logic [N-1:0][2:0]    s_awsize;
    logic [N-1:0][1:0]    s_awburst;
    logic [N-1:0]         s_awvalid, s_awready;
    logic [N-1:0][DW-1:0] s_wdata;
    logic [N-1:0][SW-1:0] s_wstrb;
    logic [N-1:0]         s_wlast, s_wvalid, s_wready;
    logic [1:0]           s_bresp;
    logic [N-1:0]         s_bvalid, s_bready;
    logic [AW-1:0]        m_awaddr;
    logic [7:0]           m_awlen;
    logic [2:0]           m_awsize;
    logic [1:0]           m_awburst;
    logic                 m_awvalid, m_awready;
    logic [DW-1:0]        m_wdata;
    logic [SW-1:0]        m_wstrb;
    logic                 m_wlast, m_wvalid, m_wready;
    logic [1:0]           m_bresp;
    logic                 m_bvalid, m_bready;
    logic [IW-1:0]        grant_id;
    logic                 busy, wlast_err;
    logic [CW-1:0]        txn_cnt;

    kf_axi_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant_id(grant_id), .busy(busy), .wlast_err(wlast_err), .txn_cnt(txn_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Requester and slave model state
    ph_t       ph[N];
    int        len[N], wl[N], bi[N], pre[N];
    bit        early[N];
    logic [AW-1:0] addr[N];
    int        vno, b_pend, cyc, last_b;
    bit        bp;
    int        order[$];
    int        beats, aw_cnt, data_err, viol_grant, viol_early, viol_gap;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int r, input int b);
        logic [31:0] w;
        w = {8'(r), 8'(vno), 16'(b)};
        return {16{w}};
    endfunction

    task automatic drive_outputs();
        for (int r = 0; r < N; r++) begin
            s_awvalid[r] = (ph[r] == PH_A);
            s_awaddr[r]  = addr[r];
            s_awlen[r]   = 8'(len[r]);
            s_awsize[r]  = 3'd6;
            s_awburst[r] = 2'b01;
            s_wvalid[r]  = (ph[r] == PH_W) || (ph[r] == PH_PRE) || (ph[r] == PH_A && early[r]);
            s_wdata[r]   = data_of(r, bi[r]);
            s_wstrb[r]   = '1;
            s_wlast[r]   = (bi[r] == wl[r]);
            s_bready[r]  = (ph[r] == PH_B);
        end
        m_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!m_bvalid) m_bvalid = (b_pend > 0) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
        m_bresp = 2'b00;
    endtask

    task automatic clear_models();
        for (int r = 0; r < N; r++) begin
            ph[r] = PH_IDLE; len[r] = 0; wl[r] = 0; bi[r] = 0; pre[r] = 0;
            early[r] = 1'b0; addr[r] = '0;
        end
        b_pend   = 0;
        m_bvalid = 1'b0;
    endtask

    task automatic setup(input int r, input bit en, input int l, input int w, input bit e);
        ph[r]    = !en ? PH_IDLE : (e ? PH_PRE : PH_A);
        len[r]   = l;
        wl[r]    = w;
        bi[r]    = 0;
        pre[r]   = 5;
        early[r] = e;
        addr[r]  = 32'h1000 + 32'(r) * 32'h100 + 32'(vno) * 32'h1_0000;
    endtask

    // One clock: handshakes are judged at the negedge (inputs are stable
    // until after the following posedge), models advance #1 after the edge.
    task automatic step();
        logic          aw_hs, w_hs, b_hs, w_last;
        logic [N-1:0]  aw_r, w_r, b_r, gmask;
        logic [AW-1:0] aw_addr;
        logic [7:0]    aw_len;
        logic [2:0]    aw_size;
        logic [1:0]    aw_burst, b_resp;
        logic [DW-1:0] w_data;
        logic [SW-1:0] w_strb;
        @(negedge clk);
        gmask = '0;
        gmask[grant_id] = 1'b1;
        if (((s_awready | s_wready | s_bvalid) & ~gmask) != '0) viol_grant++;
        for (int r = 0; r < N; r++) if (s_wready[r] && ph[r] != PH_W) viol_early++;
        aw_hs = m_awvalid && m_awready;
        w_hs  = m_wvalid && m_wready;
        b_hs  = m_bvalid && m_bready;
        aw_r  = s_awvalid & s_awready;
        w_r   = s_wvalid & s_wready;
        b_r   = s_bvalid & s_bready;
        aw_addr = m_awaddr; aw_len = m_awlen; aw_size = m_awsize; aw_burst = m_awburst;
        w_data = m_wdata; w_strb = m_wstrb; w_last = m_wlast; b_resp = s_bresp;
        @(posedge clk);
        #1;
        cyc++;
        if (aw_hs) begin
            aw_cnt++;
            if (cyc - last_b < 2) viol_gap++;
            if ($countones(aw_r) != 1) data_err++;
            for (int r = 0; r < N; r++) begin
                if (aw_r[r]) begin
                    order.push_back(r);
                    if (aw_addr !== addr[r] || aw_len !== 8'(len[r]) ||
                        aw_size !== 3'd6 || aw_burst !== 2'b01) data_err++;
                    ph[r] = PH_W;
                    bi[r] = 0;
                end
            end
        end else if (aw_r != '0) begin
            data_err++;
        end
        if (w_hs) begin
            beats++;
            if ($countones(w_r) != 1) data_err++;
            for (int r = 0; r < N; r++) begin
                if (w_r[r]) begin
                    if (w_data !== data_of(r, bi[r]) || w_strb !== '1 ||
                        w_last !== (bi[r] == wl[r])) data_err++;
                    if (bi[r] == wl[r]) ph[r] = PH_B;
                    else bi[r]++;
                end
            end
            if (w_last) b_pend++;
        end else if (w_r != '0) begin
            data_err++;
        end
        if (b_hs) begin
            b_pend--;
            m_bvalid = 1'b0;
            last_b   = cyc;
            if ($countones(b_r) != 1 || b_resp !== 2'b00) data_err++;
            for (int r = 0; r < N; r++) if (b_r[r]) ph[r] = PH_IDLE;
        end else if (b_r != '0) begin
            data_err++;
        end
        for (int r = 0; r < N; r++) begin
            if (ph[r] == PH_PRE) begin
                pre[r]--;
                if (pre[r] == 0) ph[r] = PH_A;
            end
        end
        drive_outputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_models();
        drive_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        bit done;
        int n_en;
        if (v.do_rst) apply_reset();
        vno = vi; bp = v.bp; order.delete();
        beats = 0; aw_cnt = 0; data_err = 0; viol_grant = 0; viol_early = 0; viol_gap = 0;
        last_b = -100; cyc = 0;
        setup(0, v.en0, v.len0, v.wl0, 1'b0);
        setup(1, v.en1, v.len1, v.wl1, v.early1);
        drive_outputs();
        n_en = int'(v.en0) + int'(v.en1);
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            step();
            done = (ph[0] == PH_IDLE) && (ph[1] == PH_IDLE) && (b_pend == 0) && !m_bvalid;
        end
        check({v.name, "_done"}, done, 1);
        check({v.name, "_ngrants"}, order.size(), n_en);
        check({v.name, "_first"}, order.size() > 0 ? order[0] : -1, v.first);
        if (n_en == 2) check({v.name, "_second"}, order.size() > 1 ? order[1] : -1, 1 - v.first);
        check({v.name, "_wbeats"}, beats, v.beats);
        check({v.name, "_awcnt"}, aw_cnt, n_en);
        check({v.name, "_data"}, data_err, 0);
        check({v.name, "_ungranted"}, viol_grant, 0);
        check({v.name, "_w_before_aw"}, viol_early, 0);
        check({v.name, "_b_aw_gap"}, viol_gap, 0);
        check({v.name, "_wlast_err"}, wlast_err, v.err);
        check({v.name, "_txn_cnt"}, txn_cnt, v.txn);
        check({v.name, "_grant_id"}, grant_id, v.gid);
        check({v.name, "_busy"}, busy, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t post;
        bit   hit;

        vecs[0] = '{"single_r0",     1, 0, 1, 3, 3, 0, 0, 0, 0, 0,  4, 0,  1, 0};
        vecs[1] = '{"pair_reset",    1, 0, 1, 1, 1, 1, 2, 2, 0, 0,  5, 0,  2, 1};
        vecs[2] = '{"pair_alt",      0, 0, 1, 0, 0, 1, 0, 0, 0, 0,  2, 0,  4, 1};
        vecs[3] = '{"single_r0b",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0,  5, 0};
        vecs[4] = '{"pair_r1_first", 0, 0, 1, 0, 0, 1, 1, 1, 0, 1,  3, 0,  7, 0};
        vecs[5] = '{"early_w_r1",    0, 0, 0, 0, 0, 1, 3, 3, 1, 1,  4, 0,  8, 1};
        vecs[6] = '{"wlast_short",   0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  1, 1,  9, 0};
        vecs[7] = '{"bp_sticky",     0, 1, 1, 7, 7, 1, 5, 5, 0, 1, 14, 1, 11, 0};
        vecs[8] = '{"bp_reset",      1, 1, 1, 2, 2, 1, 3, 3, 0, 0,  7, 0,  2, 1};
        post    = '{"post_reset",    0, 0, 1, 0, 0, 1, 0, 0, 0, 0,  2, 0,  2, 1};

        // Reset state
        rst = 1'b1; bp = 1'b0; vno = 0;
        clear_models();
        drive_outputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_awvalid", m_awvalid, 0);
        check("rst_m_awaddr", m_awaddr, 0);
        check("rst_m_wvalid", m_wvalid, 0);
        check("rst_m_bready", m_bready, 0);
        check("rst_s_awready", s_awready, 0);
        check("rst_s_wready", s_wready, 0);
        check("rst_s_bvalid", s_bvalid, 0);
        check("rst_s_bresp", s_bresp, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_wlast_err", wlast_err, 0);
        check("rst_txn_cnt", txn_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset asserted during beat 2 of an 8-beat burst from requester 0
        vno = 9; bp = 1'b0; last_b = -100; cyc = 0;
        setup(0, 1'b1, 7, 7, 1'b0);
        drive_outputs();
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            hit = (ph[0] == PH_W) && (bi[0] == 2);
        end
        check("midrst_reached_beat2", hit, 1);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_m_wvalid", m_wvalid, 0);
        check("midrst_m_awvalid", m_awvalid, 0);
        check("midrst_s_wready", s_wready, 0);
        check("midrst_m_bready", m_bready, 0);
        check("midrst_txn_cnt", txn_cnt, 0);
        clear_models();
        drive_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(post, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
